// File: rtl/div_unit.sv
// div_unit: iterative 32-bit RV32M divider (DIV/DIVU/REM/REMU).
// Restoring shift-subtract, one quotient bit per cycle, MSB first.
// Compile option: DIV_EARLY_OUT_EN. When defined, divide-by-zero and
// signed overflow skip CALC and report in the cycle after acceptance.
module div_unit (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [1:0]  op,
  input  logic [31:0] dividend,
  input  logic [31:0] divisor,
  input  logic        kill,
  output logic        busy,
  output logic        done,
  output logic [31:0] result
);

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

  state_t      state, state_nxt;
  logic [4:0]  cnt;
  logic [31:0] rem_q;     // partial remainder (magnitude)
  logic [31:0] quo_q;     // dividend bits shift out as quotient bits shift in
  logic [31:0] dvs_q;     // divisor magnitude
  logic        is_rem_q, qsign_q, rsign_q;

  // op[0] = unsigned, op[1] = remainder
  logic        signed_op, accept;
  logic [31:0] abs_a, abs_b;
  assign signed_op = ~op[0];
  assign accept    = (state == IDLE) && start && !kill;
  assign abs_a     = (signed_op && dividend[31]) ? -dividend : dividend;
  assign abs_b     = (signed_op && divisor[31])  ? -divisor  : divisor;

`ifdef DIV_EARLY_OUT_EN
  logic div_zero, sovf, early;
  assign div_zero = (divisor == 32'h0);
  assign sovf     = signed_op && (dividend == 32'h8000_0000) && (divisor == 32'hFFFF_FFFF);
  assign early    = div_zero || sovf;
`endif

  // One restoring step: 33-bit working remainder, keep it if the trial
  // subtraction does not go negative.
  logic [32:0] r_sh, diff;
  logic        ge;
  assign r_sh = {rem_q, quo_q[31]};
  assign diff = r_sh - {1'b0, dvs_q};
  assign ge   = ~diff[32];

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Next-state logic; kill overrides every transition
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (start) begin
`ifdef DIV_EARLY_OUT_EN
        state_nxt = early ? DONE : CALC;
`else
        state_nxt = CALC;
`endif
      end
      CALC: if (cnt == 5'd31) state_nxt = DONE;
      DONE: state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
    if (kill) state_nxt = IDLE;
  end

  // Operand capture on accept, one divide step per CALC cycle
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt      <= '0;
      rem_q    <= '0;
      quo_q    <= '0;
      dvs_q    <= '0;
      is_rem_q <= 1'b0;
      qsign_q  <= 1'b0;
      rsign_q  <= 1'b0;
    end else if (accept) begin
      cnt      <= '0;
      is_rem_q <= op[1];
      // A zero divisor must give all-ones quotient regardless of sign.
      qsign_q  <= signed_op && (dividend[31] ^ divisor[31]) && (divisor != 32'h0);
      rsign_q  <= signed_op && dividend[31];
      rem_q    <= '0;
      quo_q    <= abs_a;
      dvs_q    <= abs_b;
`ifdef DIV_EARLY_OUT_EN
      if (div_zero) begin
        quo_q <= 32'hFFFF_FFFF;
        rem_q <= abs_a;
      end else if (sovf) begin
        quo_q   <= 32'h8000_0000;
        qsign_q <= 1'b0;
      end
`endif
    end else if (state == CALC) begin
      cnt   <= cnt + 5'd1;
      rem_q <= ge ? diff[31:0] : r_sh[31:0];
      quo_q <= {quo_q[30:0], ge};
    end
  end

  // Outputs: result is forced to zero outside the done cycle
  always_comb begin
    busy   = (state != IDLE);
    done   = (state == DONE);
    result = '0;
    if (done) begin
      if (is_rem_q) result = rsign_q ? -rem_q : rem_q;
      else          result = qsign_q ? -quo_q : quo_q;
    end
  end

endmodule
